// File: rtl/sr_command_generator_pkg.sv
// Shared definitions for the SR flip-flop command stage: command encodings,
// default debounce length and channel indexing. The flip-flop benches reuse these.
package sr_command_generator_pkg;

    // Default number of consecutive differing cycles before a level flips.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Command encodings as presented on {s, r}. 2'b11 is deliberately absent.
    typedef enum logic [1:0] {
        CMD_HOLD  = 2'b00,
        CMD_RESET = 2'b01,
        CMD_SET   = 2'b10
    } cmd_t;

    // Channel indices used by the top level when building per-button arrays.
    localparam int CH_RESET = 0;
    localparam int CH_SET   = 1;
    localparam int NUM_CH   = 2;

    // Width of a counter that must hold values 0 .. cycles-1.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : sr_command_generator_pkg

// File: rtl/sr_command_generator_debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, debounced level
// register and a registered one-cycle flag marking each 0->1 level flip.
module debounce_channel
    import sr_command_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)(
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                 CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    // Counter value at which a still-differing input is accepted.
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_level_next;
    logic             w_rise_next;
    logic             w_differs;

    assign w_differs = (r_sync2 != r_level);

    // Debounce decision: count while the synchronised input disagrees with the
    // accepted level, restart on any agreement, flip and clear on the last count.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_rise_next  = 1'b0;
        if (w_differs) begin
            if (r_cnt == CNT_LAST) begin
                w_level_next = r_sync2;
                w_cnt_next   = '0;
                // Only a press (new level 1) is flagged; release is silent.
                w_rise_next  = r_sync2;
            end else begin
                w_cnt_next   = r_cnt + CNT_W'(1);
            end
        end else begin
            w_cnt_next = '0;
        end
    end

    // Synchroniser and debounce state; reset clears everything so a button held
    // through reset is qualified again as a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_rise  <= w_rise_next;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule : debounce_channel

// File: rtl/sr_command_generator.sv
// Command stage for the SR flip-flop: debounces the set/reset buttons and turns
// each debounced press into a single-cycle s or r pulse, reset-dominant, never 11.
module sr_command_generator
    import sr_command_generator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)(
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_reset,
    output logic s,
    output logic r,
    output logic set_level,
    output logic reset_level
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_rise;
    cmd_t              w_cmd;

    assign w_raw[CH_SET]   = btn_set;
    assign w_raw[CH_RESET] = btn_reset;

    // One identical debounce channel per button.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_channel (
            .clk   (clk),
            .reset (reset),
            .raw   (w_raw[gi]),
            .level (w_level[gi]),
            .rise  (w_rise[gi])
        );
    end

    // Arbitration of the registered rise flags: reset wins, and a set that
    // qualifies on the same edge is dropped rather than deferred. Only flop
    // outputs feed this, so there is no path from the raw buttons to s/r.
    always_comb begin
        w_cmd = CMD_HOLD;
        if (w_rise[CH_RESET]) begin
            w_cmd = CMD_RESET;
        end else if (w_rise[CH_SET]) begin
            w_cmd = CMD_SET;
        end
    end

    assign {s, r}      = w_cmd;
    assign set_level   = w_level[CH_SET];
    assign reset_level = w_level[CH_RESET];

endmodule : sr_command_generator

// File: tb/tb_sr_command_generator.sv
// Directed bench for sr_command_generator with DEBOUNCE_CYCLES=4: pulse timing,
// glitch rejection, reset dominance, re-press spacing and reset behaviour.
module tb_sr_command_generator;
    import sr_command_generator_pkg::*;

    logic clk         = 1'b0;
    logic reset       = 1'b1;
    logic btn_set     = 1'b0;
    logic btn_reset   = 1'b0;
    logic s;
    logic r;
    logic set_level;
    logic reset_level;

    int errors     = 0;
    int checks     = 0;
    int cyc        = 0;
    int s_cnt      = 0;
    int r_cnt      = 0;
    int s_last     = -1;
    int r_last     = -1;
    int both_cnt   = 0;
    int rl_changes = 0;
    logic rl_prev  = 1'b0;
    int b;

    sr_command_generator #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_set     (btn_set),
        .btn_reset   (btn_reset),
        .s           (s),
        .r           (r),
        .set_level   (set_level),
        .reset_level (reset_level)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one rising edge, then record what the DUT shows after it.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (s === 1'b1) begin
            s_cnt++;
            s_last = cyc;
        end
        if (r === 1'b1) begin
            r_cnt++;
            r_last = cyc;
        end
        if (s === 1'b1 && r === 1'b1) begin
            both_cnt++;
        end
        if (reset_level !== rl_prev) begin
            rl_changes++;
        end
        rl_prev = reset_level;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    task automatic clear_counts();
        s_cnt      = 0;
        r_cnt      = 0;
        s_last     = -1;
        r_last     = -1;
        rl_changes = 0;
        rl_prev    = reset_level;
    endtask

    initial begin
        // Reset held 3 edges with both buttons pressed.
        reset     = 1'b1;
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        steps(3);
        check("rst_s", 32'(s), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_set_level", 32'(set_level), 32'd0);
        check("rst_reset_level", 32'(reset_level), 32'd0);

        // Both held through reset release: both qualify together, reset wins.
        clear_counts();
        reset = 1'b0;
        b = cyc;
        steps(5);
        check("held_pre_r", 32'(r), 32'd0);
        step();
        check("held_cmd", 32'({s, r}), 32'(CMD_RESET));
        steps(20);
        check("held_r_cnt", 32'(r_cnt), 32'd1);
        check("held_s_cnt", 32'(s_cnt), 32'd0);
        check("held_r_edge", 32'(r_last), 32'(b + 6));
        check("held_set_level", 32'(set_level), 32'd1);
        check("held_reset_level", 32'(reset_level), 32'd1);
        $display("edge %0d: reset/held-press r_cnt=%0d s_cnt=%0d", cyc, r_cnt, s_cnt);

        // Release both: levels drop, no pulses.
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        steps(20);
        check("rel_r_cnt", 32'(r_cnt), 32'd1);
        check("rel_s_cnt", 32'(s_cnt), 32'd0);
        check("rel_set_level", 32'(set_level), 32'd0);
        check("rel_reset_level", 32'(reset_level), 32'd0);
        $display("edge %0d: release both levels=%0d%0d", cyc, set_level, reset_level);

        // Clean press of set: pulse exactly at b+6, single pulse while held.
        clear_counts();
        b = cyc;
        btn_set = 1'b1;
        steps(5);
        check("press_pre_s", 32'(s), 32'd0);
        check("press_pre_level", 32'(set_level), 32'd0);
        step();
        check("press_cmd", 32'({s, r}), 32'(CMD_SET));
        check("press_level", 32'(set_level), 32'd1);
        step();
        check("press_fall_s", 32'(s), 32'd0);
        steps(100);
        check("press_s_cnt", 32'(s_cnt), 32'd1);
        check("press_s_edge", 32'(s_last), 32'(b + 6));
        btn_set = 1'b0;
        steps(12);
        $display("edge %0d: clean press s_cnt=%0d at edge %0d", cyc, s_cnt, s_last);

        // Bounce on reset button 1,0,1,0 then hold: one pulse when settled.
        clear_counts();
        b = cyc;
        btn_reset = 1'b1; step();
        btn_reset = 1'b0; step();
        btn_reset = 1'b1; step();
        btn_reset = 1'b0; step();
        btn_reset = 1'b1;
        steps(10);
        check("bounce_r_cnt", 32'(r_cnt), 32'd1);
        check("bounce_r_edge", 32'(r_last), 32'(b + 10));
        check("bounce_s_cnt", 32'(s_cnt), 32'd0);
        check("bounce_level_changes", 32'(rl_changes), 32'd1);
        btn_reset = 1'b0;
        steps(12);
        $display("edge %0d: bounce r_cnt=%0d at edge %0d", cyc, r_cnt, r_last);

        // Simultaneous press: one r pulse, set dropped.
        clear_counts();
        b = cyc;
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        steps(20);
        check("simul_r_cnt", 32'(r_cnt), 32'd1);
        check("simul_s_cnt", 32'(s_cnt), 32'd0);
        check("simul_r_edge", 32'(r_last), 32'(b + 6));
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        steps(12);
        $display("edge %0d: simultaneous r_cnt=%0d s_cnt=%0d", cyc, r_cnt, s_cnt);

        // Release-and-re-press: long release gives a second pulse, short does not.
        clear_counts();
        btn_set = 1'b1;
        steps(12);
        btn_set = 1'b0;
        steps(6);
        btn_set = 1'b1;
        steps(12);
        check("repress_long_s_cnt", 32'(s_cnt), 32'd2);
        btn_set = 1'b0;
        steps(2);
        btn_set = 1'b1;
        steps(12);
        check("repress_short_s_cnt", 32'(s_cnt), 32'd2);
        btn_set = 1'b0;
        steps(12);
        $display("edge %0d: re-press s_cnt=%0d", cyc, s_cnt);

        // Reset two edges into qualification: aborted, then fresh pulse 6 edges on.
        clear_counts();
        btn_set = 1'b1;
        steps(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        b = cyc;
        steps(5);
        check("midrst_no_early_pulse", 32'(s_cnt), 32'd0);
        step();
        check("midrst_s", 32'(s), 32'd1);
        steps(10);
        check("midrst_s_cnt", 32'(s_cnt), 32'd1);
        check("midrst_s_edge", 32'(s_last), 32'(b + 6));
        btn_set = 1'b0;
        steps(12);
        $display("edge %0d: reset mid-qualification s_cnt=%0d at edge %0d", cyc, s_cnt, s_last);

        // {s,r} must never have shown 11 on any observed edge.
        check("never_11", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sr_command_generator
